spi_master: RTL and testbench

Byte-wide SPI bus master that drives spi_clk, spi_ss and MOSI, and samples MISO. It serialises one 8-bit word per start request, MSB first, and returns the received word on bus_out. All four CPOL/CPHA modes are supported, and the SCK rate is programmable. It sits beside the existing SPI slave logic so the FPGA can also initiate transfers to external SPI peripherals.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_master_timer.sv | 27 ++
 rtl/spi_master.sv | 168 ++++++++++++++++
 tb/tb_spi_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, mode encodings, default width.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_master_timer.sv
// Half-period divider: counts enabled cycles 0..div and flags the last one with tick.
module spi_master_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Wrapping at div (not at 2^DIV_W) lets div = max give a full 2^DIV_W period.
  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI bus master, all four CPOL/CPHA modes, programmable SCK half-period.
//
// state | meaning
// IDLE  | ss high, SCK follows CPOL input, waiting for start
// SETUP | ss low, one half-period before the first SCK edge
// XFER  | 2*DATA_W half-periods, SCK toggles at the start of each
// HOLD  | one half-period with ss still low, then done
module spi_master
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_clk_polarity,
  input  logic              spi_clk_phase,
  input  logic [DIV_W-1:0]  div,
  input  logic              start,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  input  logic              spi_in,
  output logic              spi_out,
  output logic              spi_clk,
  output logic              spi_ss
);

  localparam int EDGE_W = $clog2(2*DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W);

  spi_state_t        state, state_nx;
  logic [DATA_W-1:0] tx_sr, tx_nx, rx_sr, rx_nx, bus_out_nx;
  logic [DIV_W-1:0]  div_q, div_nx;
  logic [EDGE_W-1:0] edge_cnt, edge_nx, edge_inc;
  logic              cpol_q, cpol_nx, cpha_q, cpha_nx;
  logic              sck_nx, mosi_nx, ss_nx, busy_nx, done_nx;
  logic              tick, tmr_clr, edge_go, lead_sample, sample_now;

  spi_master_timer #(.DIV_W(DIV_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (tmr_clr),
    .div  (div_q),
    .tick (tick)
  );

  assign edge_inc = edge_cnt + 1'b1;
  assign tmr_clr  = (state == IDLE) || (state_nx != state);

  always_comb begin
    case ({cpol_q, cpha_q})
      MODE0, MODE2: lead_sample = 1'b1;
      MODE1, MODE3: lead_sample = 1'b0;
      default:      lead_sample = 1'b1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    tx_nx      = tx_sr;
    rx_nx      = rx_sr;
    div_nx     = div_q;
    cpol_nx    = cpol_q;
    cpha_nx    = cpha_q;
    edge_nx    = edge_cnt;
    bus_out_nx = bus_out;
    sck_nx     = spi_clk;
    mosi_nx    = spi_out;
    ss_nx      = spi_ss;
    busy_nx    = busy;
    done_nx    = 1'b0;
    edge_go    = 1'b0;
    sample_now = 1'b0;

    case (state)
      IDLE: begin
        sck_nx = spi_clk_polarity;
        if (start) begin
          tx_nx    = bus_in;
          rx_nx    = '0;
          div_nx   = div;
          cpol_nx  = spi_clk_polarity;
          cpha_nx  = spi_clk_phase;
          edge_nx  = '0;
          ss_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = SETUP;
          if (!spi_clk_phase) mosi_nx = bus_in[DATA_W-1];
        end
      end
      SETUP: begin
        if (tick) begin
          state_nx = XFER;
          edge_go  = 1'b1;
        end
      end
      XFER: begin
        if (tick) begin
          if (edge_cnt == LAST_EDGE) state_nx = HOLD;
          else                       edge_go  = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          ss_nx      = 1'b1;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          bus_out_nx = rx_sr;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Odd-numbered edges are leading edges; CPHA picks which parity samples.
    if (edge_go) begin
      edge_nx    = edge_inc;
      sck_nx     = ~spi_clk;
      sample_now = (edge_inc[0] == lead_sample);
      if (sample_now) begin
        rx_nx = {rx_sr[DATA_W-2:0], spi_in};
      end else if (cpha_q) begin
        mosi_nx = tx_sr[DATA_W-1];
        tx_nx   = {tx_sr[DATA_W-2:0], 1'b0};
      end else if (edge_inc != LAST_EDGE) begin
        mosi_nx = tx_sr[DATA_W-2];
        tx_nx   = {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
      bus_out  <= '0;
      spi_clk  <= 1'b0;
      spi_out  <= 1'b0;
      spi_ss   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (ena) begin
      state    <= state_nx;
      tx_sr    <= tx_nx;
      rx_sr    <= rx_nx;
      div_q    <= div_nx;
      cpol_q   <= cpol_nx;
      cpha_q   <= cpha_nx;
      edge_cnt <= edge_nx;
      bus_out  <= bus_out_nx;
      spi_clk  <= sck_nx;
      spi_out  <= mosi_nx;
      spi_ss   <= ss_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: a timing/data model of the SPI transfer checked against the DUT every cycle.
module tb_spi_master;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       pol = 1'b0;
  logic       pha = 1'b0;
  logic       start = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] bus_in = 8'd0;
  logic [7:0] bus_out;
  logic       busy, done, spi_in, spi_out, spi_clk, spi_ss;
  logic       slave_bit = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] slave_byte = 8'd0;

  assign spi_in = loop ? spi_out : slave_bit;

  spi_master #(.DIV_W(8), .DATA_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .spi_clk_polarity (pol),
    .spi_clk_phase    (pha),
    .div              (div),
    .start            (start),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .busy             (busy),
    .done             (done),
    .spi_in           (spi_in),
    .spi_out          (spi_out),
    .spi_clk          (spi_clk),
    .spi_ss           (spi_ss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ena_mode = 0;

  // Model state: n counts enabled cycles since acceptance (n=1 is the first ss-low cycle).
  bit         m_active = 1'b0;
  bit         m_done_now = 1'b0;
  bit         m_idle_sck = 1'b0;
  bit         m_cpol = 1'b0;
  bit         m_cpha = 1'b0;
  int         m_n = 0;
  int         m_H = 1;
  logic [7:0] m_tx = 8'd0;
  logic [7:0] m_S = 8'd0;
  logic [7:0] m_bus_out = 8'd0;

  int         tog_cnt = 0, first_tog = 0, half_meas = 0, ss_low_cnt = 0;
  int         dut_done_cnt = 0, done_rise_edge = 0, ss_fall_edge = 0;
  logic [7:0] mosi_rise = 8'd0;
  logic       prev_sck = 1'b0, prev_done = 1'b0, prev_ss = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int edges_seen(input int n, input int h);
    int e;
    if (n < h + 1) return 0;
    e = (n - h - 1) / h + 1;
    return (e > 16) ? 16 : e;
  endfunction

  always @(posedge clk) begin
    logic       r_s, e_s, st_s, p_s, ph_s;
    logic [7:0] d_s, b_s;
    int         e, samples;
    cyc++;
    r_s = rst; e_s = ena; st_s = start; p_s = pol; ph_s = pha; d_s = div; b_s = bus_in;
    if (!r_s) begin
      m_active = 1'b0; m_done_now = 1'b0; m_idle_sck = 1'b0; m_bus_out = 8'd0; m_n = 0;
    end else if (e_s) begin
      m_done_now = 1'b0;
      if (m_active) begin
        m_n++;
        if (m_n == 18 * m_H + 1) begin
          m_active = 1'b0; m_done_now = 1'b1; m_bus_out = m_S; m_idle_sck = m_cpol;
        end
      end else begin
        m_idle_sck = p_s;
        if (st_s) begin
          m_active = 1'b1; m_n = 1; m_H = int'(d_s) + 1;
          m_cpol = p_s; m_cpha = ph_s; m_tx = b_s; m_S = loop ? b_s : slave_byte;
          tog_cnt = 0; half_meas = 0; ss_low_cnt = 0;
        end
      end
    end
    #1;
    if (rst) begin
      if (m_active) begin
        e = edges_seen(m_n, m_H);
        chk("ss", 32'(spi_ss), 32'd0);
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'd0);
        chk("sck", 32'(spi_clk), 32'(m_cpol ^ e[0]));
        if (e > 0 && m_n <= 17 * m_H && ((m_n - m_H - 1) % m_H) == 0 && (e[0] != m_cpha))
          chk("mosi", 32'(spi_out), 32'(m_tx[7 - ((e - 1) / 2)]));
      end else begin
        chk("ss", 32'(spi_ss), 32'd1);
        chk("busy", 32'(busy), 32'd0);
        chk("done", 32'(done), 32'(m_done_now));
        chk("sck_idle", 32'(spi_clk), 32'(m_idle_sck));
      end
      chk("bus_out", 32'(bus_out), 32'(m_bus_out));
      if (m_active && spi_clk != prev_sck) begin
        tog_cnt++;
        if (tog_cnt == 1) first_tog = cyc;
        if (tog_cnt == 2) half_meas = cyc - first_tog;
        if (spi_clk) mosi_rise = {mosi_rise[6:0], spi_out};
      end
      if (m_active && !spi_ss) ss_low_cnt++;
      if (done && !prev_done) begin dut_done_cnt++; done_rise_edge = cyc; end
      if (!spi_ss && prev_ss) ss_fall_edge = cyc;
      prev_sck = spi_clk; prev_done = done; prev_ss = spi_ss;
      if (m_active) begin
        e = edges_seen(m_n, m_H);
        samples = m_cpha ? e / 2 : (e + 1) / 2;
        slave_bit = (samples < 8) ? m_S[7 - samples] : 1'b0;
      end else begin
        slave_bit = 1'b0;
      end
    end else begin
      prev_sck = 1'b0; prev_done = 1'b0; prev_ss = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    case (ena_mode)
      0:       ena = 1'b1;
      1:       ena = ~ena;
      default: ena = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic wait_accept();
    int guard = 0;
    while (!m_active && guard < 100) begin step(); guard++; end
    if (!m_active) chk("accept_timeout", 32'(m_active), 32'd1);
  endtask

  task automatic wait_done(input bit scramble);
    int guard = 0;
    while (m_active && guard < 20000) begin
      step();
      if (scramble) begin
        pol = 1'($urandom); pha = 1'($urandom); div = 8'($urandom); bus_in = 8'($urandom);
      end
      guard++;
    end
    if (m_active) chk("done_timeout", 32'(m_active), 32'd0);
  endtask

  task automatic run_xfer(input logic [1:0] md, input logic [7:0] d, input logic [7:0] tx,
                          input logic [7:0] sb, input bit lp, input bit scramble);
    step();
    {pol, pha} = md; div = d; bus_in = tx; slave_byte = sb; loop = lp; start = 1'b1;
    step();
    wait_accept();
    start = 1'b0;
    wait_done(scramble);
  endtask

  logic [1:0] modes [4];

  initial begin
    int d0, start_edge, guard;
    modes = '{MODE0, MODE1, MODE2, MODE3};
    repeat (3) step();
    chk("rst_ss", 32'(spi_ss), 32'd1);
    chk("rst_sck", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    rst = 1'b1;
    repeat (2) step();

    // mode 0, div 0, loopback
    run_xfer(MODE0, 8'd0, 8'hA5, 8'h00, 1'b1, 1'b0);
    chk("t1_mosi_rise", 32'(mosi_rise), 32'h0000_00A5);
    chk("t1_done_at", 32'(done_rise_edge - ss_fall_edge + 1), 32'd19);
    chk("t1_bus_out", 32'(bus_out), 32'h0000_00A5);
    chk("t1_ss_low", 32'(ss_low_cnt), 32'd18);

    // all four modes, div 3, slave returns C3
    for (int m = 0; m < 4; m++) begin
      step();
      pol = modes[m][1];
      repeat (2) step();
      chk("t2_sck_before", 32'(spi_clk), 32'(modes[m][1]));
      run_xfer(modes[m], 8'd3, 8'h3C, 8'hC3, 1'b0, 1'b0);
      chk("t2_bus_out", 32'(bus_out), 32'h0000_00C3);
      chk("t2_toggles", 32'(tog_cnt), 32'd16);
      chk("t2_half", 32'(half_meas), 32'd4);
      step();
      chk("t2_sck_after", 32'(spi_clk), 32'(modes[m][1]));
    end

    // start held and pulsed during a transfer, then held across done
    step();
    pol = 1'b0; pha = 1'b0; div = 8'd1; bus_in = 8'h5A; slave_byte = 8'h96; loop = 1'b0; start = 1'b1;
    step();
    wait_accept();
    repeat (4) step();
    start = 1'b0; repeat (3) step();
    start = 1'b1; step(); start = 1'b0; repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    d0 = dut_done_cnt;
    start = 1'b1;
    guard = 0;
    while (!(dut_done_cnt != d0 && m_active) && guard < 200) begin step(); guard++; end
    chk("t3_one_done", 32'(dut_done_cnt - d0), 32'd1);
    chk("t3_restart_gap", 32'(ss_fall_edge - done_rise_edge), 32'd1);
    chk("t3_bus_out", 32'(bus_out), 32'h0000_0096);
    start = 1'b0;
    wait_done(1'b0);

    // ena toggling every cycle, start raised in a disabled cycle
    ena_mode = 1;
    pol = 1'b0; pha = 1'b0; div = 8'd0; bus_in = 8'h81; loop = 1'b1;
    guard = 0;
    step();
    while (ena != 1'b0 && guard < 4) begin step(); guard++; end
    start = 1'b1;
    start_edge = cyc + 1;
    step();
    wait_accept();
    start = 1'b0;
    wait_done(1'b0);
    chk("t4_done_at", 32'(done_rise_edge - start_edge + 1), 32'd38);
    chk("t4_bus_out", 32'(bus_out), 32'h0000_0081);
    ena_mode = 0;

    // async reset after edge 7
    step();
    pol = 1'b0; pha = 1'b1; div = 8'd2; bus_in = 8'($urandom); loop = 1'b0; slave_byte = 8'h77; start = 1'b1;
    step();
    wait_accept();
    start = 1'b0;
    guard = 0;
    while (edges_seen(m_n, m_H) < 7 && guard < 100) begin step(); guard++; end
    d0 = dut_done_cnt;
    #2 rst = 1'b0;
    #1;
    chk("t5_ss", 32'(spi_ss), 32'd1);
    chk("t5_sck", 32'(spi_clk), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_bus_out", 32'(bus_out), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    chk("t5_no_done", 32'(dut_done_cnt - d0), 32'd0);
    run_xfer(MODE2, 8'd1, 8'hE7, 8'h1B, 1'b0, 1'b0);
    chk("t5_after_bus_out", 32'(bus_out), 32'h0000_001B);

    // maximum divider, mode 3
    run_xfer(MODE3, 8'hFF, 8'h69, 8'hD2, 1'b0, 1'b0);
    chk("t6_half", 32'(half_meas), 32'd256);
    chk("t6_toggles", 32'(tog_cnt), 32'd16);
    chk("t6_bus_out", 32'(bus_out), 32'h0000_00D2);

    // randomized transfers with random ena and inputs scrambled while busy
    ena_mode = 2;
    for (int i = 0; i < 25; i++)
      run_xfer(2'($urandom), 8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
               1'($urandom), 1'b1);
    ena_mode = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
